// File: rtl/stand_mode_exit_controller_pkg.sv
// Shared definitions for the standby-exit controller: hood mode codes,
// the default mode-code width and the controller state type.
package stand_mode_exit_controller_pkg;

  localparam int unsigned SMEC_MODE_WIDTH = 3;

  localparam logic [SMEC_MODE_WIDTH-1:0] STANDBY_MODE = 3'd0;
  localparam logic [SMEC_MODE_WIDTH-1:0] FIRST_MODE   = 3'd1;
  localparam logic [SMEC_MODE_WIDTH-1:0] SECOND_MODE  = 3'd2;
  localparam logic [SMEC_MODE_WIDTH-1:0] THIRD_MODE   = 3'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PENDING,
    ST_FIRE,
    ST_LOCKOUT
  } smec_state_t;

endpackage

// File: rtl/stand_mode_exit_controller_toggle_edge_detect.sv
// Rising-edge detector for the debounced toggle level.
// The history register resets high so a level already high when reset
// releases is not mistaken for a fresh press.
// Ports:
//   clk   - clock
//   rstn  - asynchronous active-low reset
//   level - debounced toggle level
//   rise  - high while level is 1 and was 0 on the previous clock
module stand_mode_exit_controller_toggle_edge_detect (
  input  logic clk,
  input  logic rstn,
  input  logic level,
  output logic rise
);

  logic level_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      level_d <= 1'b1;
    end else begin
      level_d <= level;
    end
  end

  assign rise = level & ~level_d;

endmodule

// File: rtl/stand_mode_exit_controller.sv
// Turns a debounced power toggle into a one-cycle "return to standby"
// request from any enabled hood mode. Selected modes get a fan run-on
// delay that a second toggle or a mode change aborts; every fire or abort
// is followed by a lockout window in which toggles are ignored.
// Ports:
//   clk            - 100 MHz clock
//   rstn           - asynchronous active-low reset
//   toggle_signal  - debounced toggle level
//   current_mode   - current mode from the mode FSM
//   standby_toggle - one-cycle pulse: go to standby
//   cancel_pulse   - one-cycle pulse: pending exit aborted
//   pending        - run-on delay in progress
//   remaining      - cycles left in run-on delay, 0 otherwise
//   source_mode    - mode latched when the request was accepted
module stand_mode_exit_controller
  import stand_mode_exit_controller_pkg::*;
#(
  parameter int unsigned           MODE_WIDTH     = SMEC_MODE_WIDTH,
  parameter int unsigned           NUM_MODES      = 4,
  parameter logic [NUM_MODES-1:0]  ENABLE_MASK    = 4'b1110,
  parameter logic [NUM_MODES-1:0]  DELAY_MASK     = 4'b1000,
  parameter int unsigned           CNT_WIDTH      = 32,
  parameter int unsigned           DELAY_CYCLES   = 500_000_000,
  parameter int unsigned           LOCKOUT_CYCLES = 10_000_000
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  toggle_signal,
  input  logic [MODE_WIDTH-1:0] current_mode,
  output logic                  standby_toggle,
  output logic                  cancel_pulse,
  output logic                  pending,
  output logic [CNT_WIDTH-1:0]  remaining,
  output logic [MODE_WIDTH-1:0] source_mode
);

  // Masks widened to every encodable mode code so they can be indexed
  // directly by current_mode; codes beyond NUM_MODES read as 0.
  localparam int unsigned MODE_SPAN = 1 << MODE_WIDTH;
  localparam logic [MODE_SPAN-1:0] EN_FULL  = MODE_SPAN'(ENABLE_MASK);
  localparam logic [MODE_SPAN-1:0] DLY_FULL = MODE_SPAN'(DELAY_MASK);

  localparam logic [CNT_WIDTH-1:0] DELAY_LOAD = CNT_WIDTH'(DELAY_CYCLES);
  localparam logic [CNT_WIDTH-1:0] LOCK_LOAD  = CNT_WIDTH'(LOCKOUT_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);
  localparam bit USE_DELAY = (DELAY_CYCLES > 0);
  localparam bit USE_LOCK  = (LOCKOUT_CYCLES > 0);

  smec_state_t          state;
  logic [CNT_WIDTH-1:0] timer;
  logic                 rise;
  logic [31:0]          mode_ext;
  logic                 in_range;
  logic                 request;
  logic                 wants_delay;
  logic                 abort;

  stand_mode_exit_controller_toggle_edge_detect u_edge (
    .clk   (clk),
    .rstn  (rstn),
    .level (toggle_signal),
    .rise  (rise)
  );

  assign mode_ext    = 32'(current_mode);
  assign in_range    = (mode_ext < NUM_MODES);
  assign request     = rise & in_range & EN_FULL[current_mode];
  assign wants_delay = USE_DELAY & DLY_FULL[current_mode];
  assign abort       = rise | (current_mode != source_mode);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state          <= ST_IDLE;
      timer          <= '0;
      standby_toggle <= 1'b0;
      cancel_pulse   <= 1'b0;
      pending        <= 1'b0;
      remaining      <= '0;
      source_mode    <= '0;
    end else begin
      standby_toggle <= 1'b0;
      cancel_pulse   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (request) begin
            source_mode <= current_mode;
            if (wants_delay) begin
              state     <= ST_PENDING;
              timer     <= DELAY_LOAD;
              pending   <= 1'b1;
              remaining <= DELAY_LOAD;
            end else begin
              state          <= ST_FIRE;
              standby_toggle <= 1'b1;
            end
          end
        end
        ST_PENDING: begin
          // Abort is checked before expiry so a coincident abort wins.
          if (abort) begin
            cancel_pulse <= 1'b1;
            pending      <= 1'b0;
            remaining    <= '0;
            if (USE_LOCK) begin
              state <= ST_LOCKOUT;
              timer <= LOCK_LOAD;
            end else begin
              state <= ST_IDLE;
            end
          end else if (timer == CNT_ONE) begin
            state          <= ST_FIRE;
            standby_toggle <= 1'b1;
            pending        <= 1'b0;
            remaining      <= '0;
          end else begin
            timer     <= timer - CNT_ONE;
            remaining <= timer - CNT_ONE;
          end
        end
        ST_FIRE: begin
          if (USE_LOCK) begin
            state <= ST_LOCKOUT;
            timer <= LOCK_LOAD;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_LOCKOUT: begin
          if (timer == CNT_ONE) begin
            state <= ST_IDLE;
          end else begin
            timer <= timer - CNT_ONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/stand_mode_exit_controller.md
# stand_mode_exit_controller

Parametrised controller that converts the debounced power toggle into a single-cycle "return to standby" request, from any hood mode. It sits between the debouncer and the mode FSM, alongside the per-mode toggle controllers. It adds per-mode enable, a fan run-on delay for selected modes with cancel-on-retoggle, and a post-action lockout. Mode codes come from the shared parameters header.

## Interface
Parameters:
- MODE_WIDTH, 3, width of mode code
- NUM_MODES, 4, number of valid mode codes (0..NUM_MODES-1)
- ENABLE_MASK, 4'b1110, bit m set = toggle from mode m accepted (standby excluded)
- DELAY_MASK, 4'b1000, bit m set = exit from mode m uses run-on delay
- CNT_WIDTH, 32, timer width
- DELAY_CYCLES, 500_000_000, run-on delay (5 s @ 100 MHz); 0 = no delay
- LOCKOUT_CYCLES, 10_000_000, post-action ignore window (100 ms); 0 = none

Ports:
- clk  in  1  100 MHz clock
- rstn  in  1  reset, asynchronous, active-low
- toggle_signal  in  1  debounced toggle level
- current_mode  in  MODE_WIDTH  current mode from mode FSM
- standby_toggle  out  1  one-cycle pulse: go to standby
- cancel_pulse  out  1  one-cycle pulse: pending exit aborted
- pending  out  1  run-on delay in progress
- remaining  out  CNT_WIDTH  cycles left in run-on delay, 0 otherwise
- source_mode  out  MODE_WIDTH  mode latched at request

## Operation
- Rising-edge detect on toggle_signal: edge = toggle_signal & ~toggle_d; toggle_d resets to 1 (input stuck high at reset release does not fire).
- Request valid: edge, current_mode < NUM_MODES, ENABLE_MASK[current_mode] = 1. Out-of-range modes ignored.
- States: IDLE, PENDING, FIRE, LOCKOUT.
- IDLE: valid request → latch source_mode; DELAY_MASK[mode] = 1 and DELAY_CYCLES > 0 → PENDING, timer = DELAY_CYCLES; else → FIRE.
- PENDING: timer decrements each cycle. Exit on first true condition, in priority: (1) edge or current_mode ≠ source_mode → cancel_pulse, LOCKOUT; (2) timer = 1 → FIRE; else stay.
- FIRE: standby_toggle = 1 for exactly this cycle; → LOCKOUT, or IDLE if LOCKOUT_CYCLES = 0.
- LOCKOUT: edges ignored; timer = LOCKOUT_CYCLES, counts down; at 1 → IDLE.
- Cancel with LOCKOUT_CYCLES = 0 → IDLE directly.
- pending = 1 only in PENDING; remaining = timer in PENDING, else 0.
- Reset values: standby_toggle 0, cancel_pulse 0, pending 0, remaining 0, source_mode 0, state IDLE, toggle_d 1.
- Reset mid-operation: all pending/lockout state discarded, no pulse emitted.

## Timing
- All outputs registered.
- Undelayed: edge sampled at clock N → standby_toggle high cycle N+1 (matches existing one-cycle controllers).
- Delayed: pending high from N+1; remaining = DELAY_CYCLES at N+1, decrements to 1; standby_toggle high at N+1+DELAY_CYCLES, pending low same cycle.
- Cancel: cancel_pulse high the cycle after the cancelling edge or mode change is sampled; pending drops same cycle.
- Cancel and expiry in same cycle → cancel wins, no standby_toggle.
- Lockout: edges in the LOCKOUT_CYCLES cycles after FIRE/cancel ignored; first edge after return to IDLE accepted.
- standby_toggle and cancel_pulse never both high.

## Structure
- Shared header parameters.vh: mode codes (STANDBY_MODE, FIRST_MODE, SECOND_MODE, THIRD_MODE), MODE_WIDTH, state encodings for this FSM.
- One sub-module: toggle_edge_detect (registered rising-edge detector, reset-high history). Timer and FSM inline.

## Test plan
- FIRST_MODE, toggle 0→1 at N → standby_toggle high only at N+1; pending stays 0; source_mode = 1.
- THIRD_MODE, DELAY_CYCLES = 10 → pending N+1..N+10, remaining 10→1, standby_toggle at N+11.
- THIRD_MODE, DELAY_CYCLES = 10, second edge at N+5 → cancel_pulse at N+6, no standby_toggle; edge during next LOCKOUT_CYCLES = 4 ignored.
- current_mode changes 3→2 during PENDING → cancel_pulse next cycle; cancel beats expiry when coincident.
- STANDBY_MODE or current_mode = 5 with edge → no outputs; toggle held high across rstn release → no pulse.
- rstn asserted at remaining = 3 → all outputs 0 immediately, no standby_toggle after release.
